// File: rtl/ndp_result_upsizer_if.sv
// AXI4-Stream pair seen by the result upsizer: 32-bit result words in, 64-bit packed beats out.
interface ndp_result_upsizer_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/ndp_result_upsizer.sv
// Packs 32-bit NDP result words into 64-bit beats, enforces the fixed frame length,
// counts frames and buffers output in a 2-entry FIFO.
module ndp_result_upsizer #(
    parameter int unsigned FRAME_WORDS = 512,
    parameter int unsigned IDX_W       = 10
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    ndp_result_upsizer_if.slave axis,
    input  logic                err_clear,
    output logic [15:0]         frame_count,
    output logic                err_early_last,
    output logic                err_missing_last,
    output logic                busy
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    typedef struct packed {
        logic [2*WORD_W-1:0] data;
        logic [7:0]          keep;
        logic                last;
    } entry_t;

    logic [WORD_W-1:0] lo_q, lo_n;
    logic              lo_valid_q, lo_valid_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    entry_t            head_q, head_n, tail_q, tail_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              ready_q, ready_n;
    logic              valid_q, valid_n;
    logic [15:0]       frames_q, frames_n;
    logic              early_q, early_n;
    logic              miss_q, miss_n;
    logic              busy_q, busy_n;

    logic   accept, pop, at_end, close, push;
    entry_t push_entry;

    // Next-state: input packing, frame checks and FIFO bookkeeping
    always_comb begin
        accept = axis.s_axis_tvalid & ready_q;
        pop    = valid_q & axis.m_axis_tready;
        at_end = (idx_q == LAST_IDX);
        close  = accept & (axis.s_axis_tlast | at_end);
        push   = accept & (lo_valid_q | close);

        lo_n       = lo_q;
        lo_valid_n = lo_valid_q;
        idx_n      = idx_q;
        head_n     = head_q;
        tail_n     = tail_q;
        count_n    = count_q;
        frames_n   = frames_q;
        early_n    = early_q;
        miss_n     = miss_q;

        if (lo_valid_q) begin
            push_entry = '{data: {axis.s_axis_tdata, lo_q}, keep: 8'hFF, last: close};
        end else begin
            push_entry = '{data: {WORD_W'(0), axis.s_axis_tdata}, keep: 8'h0F, last: 1'b1};
        end

        if (accept) begin
            idx_n = close ? '0 : idx_q + IDX_W'(1);
            if (lo_valid_q) begin
                lo_valid_n = 1'b0;
            end else if (!close) begin
                lo_n       = axis.s_axis_tdata;
                lo_valid_n = 1'b1;
            end
        end

        if (close) frames_n = frames_q + 16'd1;

        // A fresh error outranks a coincident clear
        if (err_clear) begin
            early_n = 1'b0;
            miss_n  = 1'b0;
        end
        if (close && axis.s_axis_tlast && !at_end) early_n = 1'b1;
        if (close && at_end && !axis.s_axis_tlast) miss_n = 1'b1;

        if (pop) head_n = tail_q;
        if (push) begin
            if (count_q == CNT_W'(0) || (count_q == CNT_W'(1) && pop)) head_n = push_entry;
            else tail_n = push_entry;
        end

        if (push && !pop) count_n = count_q + CNT_W'(1);
        else if (!push && pop) count_n = count_q - CNT_W'(1);

        ready_n = (count_n != CNT_W'(2));
        valid_n = (count_n != CNT_W'(0));
        busy_n  = lo_valid_n | (count_n != CNT_W'(0)) | (idx_n != '0);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            lo_q       <= '0;
            lo_valid_q <= 1'b0;
            idx_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            frames_q   <= '0;
            early_q    <= 1'b0;
            miss_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            lo_q       <= lo_n;
            lo_valid_q <= lo_valid_n;
            idx_q      <= idx_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            count_q    <= count_n;
            ready_q    <= ready_n;
            valid_q    <= valid_n;
            frames_q   <= frames_n;
            early_q    <= early_n;
            miss_q     <= miss_n;
            busy_q     <= busy_n;
        end
    end

    assign axis.s_axis_tready = ready_q;
    assign axis.m_axis_tvalid = valid_q;
    assign axis.m_axis_tdata  = head_q.data;
    assign axis.m_axis_tkeep  = head_q.keep;
    assign axis.m_axis_tlast  = head_q.last;
    assign frame_count        = frames_q;
    assign err_early_last     = early_q;
    assign err_missing_last   = miss_q;
    assign busy               = busy_q;
endmodule
